// File: rtl/i2c_master_byte.sv
// i2c_master_byte: single-byte I2C master for the PCF8574 LCD backpack.
// Accepts one request, runs START..STOP on scl/sda, reports via o_busy.
module i2c_master_byte #(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCL_HZ     = 100_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_valid,
  input  logic       i_RW,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic [7:0] o_rd_data,
  output logic       o_ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int QUARTER = SYS_CLK_HZ / (4 * SCL_HZ);
  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK_A, WDATA, RDATA, ACK_D, STOP
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qph_q, qph_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    abyte_q, wbyte_q, rx_q, rd_q;
  logic          err_q, ack_q, ack_err_q;
  logic          sda_oe, sda_in;
  logic          q_end, samp, bit_end;

  assign sda_in  = sda;
  assign q_end   = (qcnt_q == QLAST);
  assign samp    = q_end && (qph_q == 2'd2);
  assign bit_end = q_end && (qph_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      qph_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      qph_q   <= qph_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      abyte_q   <= '0;
      wbyte_q   <= '0;
      rx_q      <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      ack_err_q <= 1'b0;
      if (state_q == IDLE && i_valid) begin
        abyte_q <= {i_addr, i_RW};
        wbyte_q <= i_data;
      end
      if (samp) begin
        ack_q <= sda_in;
        if (state_q == RDATA)
          rx_q <= {rx_q[6:0], sda_in};
        // a read's ACK_D slot is the master's own NACK, never an error
        if (state_q == ACK_A || (state_q == ACK_D && !abyte_q[0]))
          err_q <= err_q | sda_in;
      end
      if (bit_end && state_q == RDATA && bit_q == 3'd7)
        rd_q <= rx_q;
      if (bit_end && state_q == STOP) begin
        ack_err_q <= err_q;
        err_q     <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    qph_d   = qph_q;
    bit_d   = bit_q;
    if (state_q == IDLE) begin
      qcnt_d = '0;
      qph_d  = '0;
      bit_d  = '0;
      if (i_valid)
        state_d = START;
    end else begin
      qcnt_d = q_end ? '0 : qcnt_q + QW'(1);
      if (q_end)
        qph_d = qph_q + 2'd1;
      if (bit_end) begin
        unique case (state_q)
          START: begin
            state_d = ADDR;
            bit_d   = '0;
          end
          ADDR: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_d = ACK_A;
          end
          WDATA, RDATA: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_d = ACK_D;
          end
          ACK_A: begin
            if (ack_q)
              state_d = STOP;
            else
              state_d = abyte_q[0] ? RDATA : WDATA;
          end
          ACK_D:   state_d = STOP;
          STOP:    state_d = IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    unique case (state_q)
      IDLE:  scl = 1'b1;
      START: sda_oe = qph_q[1];
      ADDR: begin
        scl    = qph_q[1];
        sda_oe = ~abyte_q[~bit_q];
      end
      WDATA: begin
        scl    = qph_q[1];
        sda_oe = ~wbyte_q[~bit_q];
      end
      ACK_A, RDATA, ACK_D: scl = qph_q[1];
      STOP: begin
        scl    = qph_q[1];
        sda_oe = (qph_q != 2'd3);
      end
      default: scl = 1'b1;
    endcase
  end

  assign sda       = sda_oe ? 1'b0 : 1'bz;
  assign o_busy    = (state_q != IDLE);
  assign o_rd_data = rd_q;
  assign o_ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// tb_i2c_master_byte: I2C slave/bus monitor plus transaction-level
// reference checks for i2c_master_byte at QUARTER=2.
module tb_i2c_master_byte;

  localparam int Q = 2;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_RW = 1'b0;
  logic [6:0] i_addr = '0;
  logic [7:0] i_data = '0;
  logic       o_busy, o_ack_err, scl;
  logic [7:0] o_rd_data;
  wire        sda;

  logic       s_drive = 1'b0;
  logic       ack_addr = 1'b1;
  logic       ack_data = 1'b1;
  logic [7:0] rd_byte = '0;

  logic [7:0] mon_q[$];
  logic       mon_ack[$];
  int         starts = 0;
  int         stops = 0;
  int         pos = 0;
  int         byten = 0;
  logic [7:0] sh = '0;
  logic       rd = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_rd = '0;

  pullup (sda);
  assign sda = s_drive ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_byte #(
    .SYS_CLK_HZ(800),
    .SCL_HZ(100)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .i_valid(i_valid),
    .i_RW(i_RW),
    .i_addr(i_addr),
    .i_data(i_data),
    .o_busy(o_busy),
    .o_rd_data(o_rd_data),
    .o_ack_err(o_ack_err),
    .scl(scl),
    .sda(sda)
  );

  // Bus monitor and slave: bits taken on SCL rise, slave drives after SCL fall.
  always @(negedge clk) begin : p_mon
    logic c_sda;
    c_sda = sda;
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && c_sda === 1'b0) begin
      starts = starts + 1;
      pos = 0;
      byten = 0;
    end
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && c_sda === 1'b1)
      stops = stops + 1;
    if (p_scl === 1'b0 && scl === 1'b1) begin
      if (pos < 8) begin
        sh = {sh[6:0], c_sda};
        if (pos == 7) begin
          mon_q.push_back(sh);
          if (byten == 0) rd = sh[0];
        end
      end else begin
        mon_ack.push_back(c_sda);
        byten = byten + 1;
      end
      pos = (pos == 8) ? 0 : pos + 1;
    end
    if (p_scl === 1'b1 && scl === 1'b0) begin
      s_drive = 1'b0;
      if (pos == 8 && byten == 0)
        s_drive = ack_addr;
      else if (pos == 8 && byten == 1 && !rd)
        s_drive = ack_data;
      else if (pos < 8 && byten == 1 && rd && ack_addr)
        s_drive = !rd_byte[7-pos];
    end
    p_scl = scl;
    p_sda = c_sda;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mbyte(int k);
    if (k < mon_q.size()) return mon_q[k];
    return 8'hxx;
  endfunction

  function automatic logic mack(int k);
    if (k < mon_ack.size()) return mon_ack[k];
    return 1'bx;
  endfunction

  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input logic aa, input logic ad, input logic [7:0] rb);
    @(negedge clk);
    ack_addr = aa;
    ack_data = ad;
    rd_byte  = rb;
    i_valid  = 1'b1;
    i_RW     = rw;
    i_addr   = a;
    i_data   = d;
    @(negedge clk);
    i_valid  = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output logic efall, output logic eearly);
    cyc = 0;
    eearly = 1'b0;
    while (o_busy === 1'b1 && cyc < 400) begin
      if (o_ack_err !== 1'b0) eearly = 1'b1;
      cyc++;
      @(negedge clk);
    end
    efall = o_ack_err;
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (scl !== 1'b1) begin n_err++; $display("FAIL rst_scl got %b exp 1", scl); end
    n_vec++;
    if (sda !== 1'b1) begin n_err++; $display("FAIL rst_sda got %b exp 1", sda); end
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    n_vec++;
    if (o_ack_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b exp 0", o_ack_err); end
    n_vec++;
    if (o_rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd got %h exp 00", o_rd_data); end
    reset_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int cyc, qb, sb, pb, ab;
    logic ef, ee;
    qb = mon_q.size(); ab = mon_ack.size(); sb = starts; pb = stops;
    issue(1'b0, 7'h27, 8'hA5, 1'b1, 1'b1, 8'h00);
    wait_done(cyc, ef, ee);
    n_vec++;
    if (cyc !== 80*Q) begin n_err++; $display("FAIL wr_len got %0d exp %0d", cyc, 80*Q); end
    n_vec++;
    if (mbyte(qb) !== 8'h4E) begin n_err++; $display("FAIL wr_addr got %h exp 4e", mbyte(qb)); end
    n_vec++;
    if (mbyte(qb+1) !== 8'hA5) begin n_err++; $display("FAIL wr_data got %h exp a5", mbyte(qb+1)); end
    n_vec++;
    if (starts - sb !== 1 || stops - pb !== 1) begin
      n_err++; $display("FAIL wr_start_stop got %0d/%0d exp 1/1", starts - sb, stops - pb);
    end
    n_vec++;
    if (ef !== 1'b0 || ee !== 1'b0) begin n_err++; $display("FAIL wr_err got %b%b exp 00", ee, ef); end
    n_vec++;
    if (mack(ab) !== 1'b0 || mack(ab+1) !== 1'b0) begin
      n_err++; $display("FAIL wr_acks got %b%b exp 00", mack(ab), mack(ab+1));
    end
    n_vec++;
    if (scl !== 1'b1 || sda !== 1'b1) begin n_err++; $display("FAIL wr_idle got %b%b exp 11", scl, sda); end
  endtask

  task automatic test_addr_nack();
    int cyc, qb, pb;
    logic ef, ee;
    qb = mon_q.size(); pb = stops;
    issue(1'b0, 7'h27, 8'h55, 1'b0, 1'b1, 8'h00);
    wait_done(cyc, ef, ee);
    n_vec++;
    if (cyc !== 44*Q) begin n_err++; $display("FAIL an_len got %0d exp %0d", cyc, 44*Q); end
    n_vec++;
    if (ef !== 1'b1 || ee !== 1'b0) begin n_err++; $display("FAIL an_err got %b%b exp 01", ee, ef); end
    n_vec++;
    if (mon_q.size() - qb !== 1 || stops - pb !== 1) begin
      n_err++; $display("FAIL an_bus got %0d bytes %0d stops exp 1/1", mon_q.size() - qb, stops - pb);
    end
    @(negedge clk);
    n_vec++;
    if (o_ack_err !== 1'b0) begin n_err++; $display("FAIL an_pulse got %b exp 0", o_ack_err); end
  endtask

  task automatic test_data_nack();
    int cyc, qb;
    logic ef, ee;
    qb = mon_q.size();
    issue(1'b0, 7'h27, 8'h0C, 1'b1, 1'b0, 8'h00);
    wait_done(cyc, ef, ee);
    n_vec++;
    if (cyc !== 80*Q) begin n_err++; $display("FAIL dn_len got %0d exp %0d", cyc, 80*Q); end
    n_vec++;
    if (ef !== 1'b1 || ee !== 1'b0) begin n_err++; $display("FAIL dn_err got %b%b exp 01", ee, ef); end
    n_vec++;
    if (mbyte(qb+1) !== 8'h0C) begin n_err++; $display("FAIL dn_data got %h exp 0c", mbyte(qb+1)); end
    @(negedge clk);
    n_vec++;
    if (o_ack_err !== 1'b0) begin n_err++; $display("FAIL dn_pulse got %b exp 0", o_ack_err); end
  endtask

  task automatic test_read();
    int cyc, qb, ab;
    logic ef, ee;
    qb = mon_q.size(); ab = mon_ack.size();
    issue(1'b1, 7'h27, 8'h00, 1'b1, 1'b1, 8'h3C);
    wait_done(cyc, ef, ee);
    exp_rd = 8'h3C;
    n_vec++;
    if (mbyte(qb) !== 8'h4F) begin n_err++; $display("FAIL rd_addr got %h exp 4f", mbyte(qb)); end
    n_vec++;
    if (o_rd_data !== exp_rd) begin n_err++; $display("FAIL rd_data got %h exp %h", o_rd_data, exp_rd); end
    n_vec++;
    if (mack(ab+1) !== 1'b1) begin n_err++; $display("FAIL rd_nack got %b exp 1", mack(ab+1)); end
    n_vec++;
    if (cyc !== 80*Q || ef !== 1'b0) begin
      n_err++; $display("FAIL rd_len got %0d/%b exp %0d/0", cyc, ef, 80*Q);
    end
  endtask

  task automatic test_hold_valid();
    int cyc, qb, extra;
    logic ef, ee;
    qb = mon_q.size();
    @(negedge clk);
    ack_addr = 1'b1; ack_data = 1'b1;
    i_valid = 1'b1; i_RW = 1'b0; i_addr = 7'h27; i_data = 8'h11;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (i == 20) i_data = 8'h22;
      @(negedge clk);
    end
    i_valid = 1'b0;
    wait_done(cyc, ef, ee);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_busy !== 1'b0) extra++;
      @(negedge clk);
    end
    n_vec++;
    if (cyc + 30 !== 80*Q) begin n_err++; $display("FAIL hv_len got %0d exp %0d", cyc + 30, 80*Q); end
    n_vec++;
    if (mon_q.size() - qb !== 2 || mbyte(qb+1) !== 8'h11) begin
      n_err++; $display("FAIL hv_data got %0d bytes last %h exp 2 bytes 11", mon_q.size() - qb, mbyte(qb+1));
    end
    n_vec++;
    if (extra !== 0) begin n_err++; $display("FAIL hv_restart got %0d exp 0", extra); end
  endtask

  task automatic test_back_to_back();
    int cyc, qb, sb;
    logic ef, ee;
    qb = mon_q.size(); sb = starts;
    @(negedge clk);
    i_valid = 1'b1; i_RW = 1'b0; i_addr = 7'h27; i_data = 8'h11;
    @(negedge clk);
    i_data = 8'h22;
    wait_done(cyc, ef, ee);
    n_vec++;
    if (scl !== 1'b1 || sda !== 1'b1 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_gap got scl %b sda %b busy %b exp 1 1 0", scl, sda, o_busy);
    end
    @(negedge clk);
    n_vec++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got %b exp 1", o_busy); end
    i_valid = 1'b0;
    wait_done(cyc, ef, ee);
    n_vec++;
    if (cyc !== 80*Q) begin n_err++; $display("FAIL b2b_len got %0d exp %0d", cyc, 80*Q); end
    n_vec++;
    if (mbyte(qb+1) !== 8'h11 || mbyte(qb+3) !== 8'h22 || starts - sb !== 2) begin
      n_err++; $display("FAIL b2b_data got %h %h starts %0d exp 11 22 2",
                        mbyte(qb+1), mbyte(qb+3), starts - sb);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, qb;
    logic ef, ee;
    issue(1'b0, 7'h27, 8'h5A, 1'b1, 1'b1, 8'h00);
    repeat (49) @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    exp_rd = 8'h00;
    n_vec++;
    if (scl !== 1'b1 || sda !== 1'b1) begin n_err++; $display("FAIL mr_bus got %b%b exp 11", scl, sda); end
    n_vec++;
    if (o_busy !== 1'b0 || o_ack_err !== 1'b0) begin
      n_err++; $display("FAIL mr_flags got %b%b exp 00", o_busy, o_ack_err);
    end
    n_vec++;
    if (o_rd_data !== exp_rd) begin n_err++; $display("FAIL mr_rd got %h exp %h", o_rd_data, exp_rd); end
    qb = mon_q.size();
    issue(1'b0, 7'h27, 8'h33, 1'b1, 1'b1, 8'h00);
    wait_done(cyc, ef, ee);
    n_vec++;
    if (cyc !== 80*Q || mbyte(qb) !== 8'h4E || mbyte(qb+1) !== 8'h33) begin
      n_err++; $display("FAIL mr_again got %0d %h %h exp %0d 4e 33", cyc, mbyte(qb), mbyte(qb+1), 80*Q);
    end
  endtask

  task automatic test_random();
    int cyc, qb, ab, nb;
    logic ef, ee, rw, aa, ad, e_err;
    logic [6:0] a;
    logic [7:0] d, rb, e0, e1;
    for (int it = 0; it < 24; it++) begin
      rw = 1'($urandom_range(0, 1));
      aa = ($urandom_range(0, 3) != 0);
      ad = ($urandom_range(0, 3) != 0);
      a  = 7'($urandom);
      d  = 8'($urandom);
      rb = 8'($urandom);
      qb = mon_q.size(); ab = mon_ack.size();
      issue(rw, a, d, aa, ad, rb);
      wait_done(cyc, ef, ee);
      // transaction-level expectations
      nb    = aa ? 2 : 1;
      e0    = {a, rw};
      e1    = rw ? rb : d;
      e_err = !aa || (!rw && !ad);
      if (rw && aa) exp_rd = rb;
      n_vec++;
      if (cyc !== (aa ? 80 : 44)*Q) begin
        n_err++; $display("FAIL rnd%0d_len got %0d exp %0d", it, cyc, (aa ? 80 : 44)*Q);
      end
      n_vec++;
      if (ef !== e_err || ee !== 1'b0) begin
        n_err++; $display("FAIL rnd%0d_err got %b%b exp 0%b", it, ee, ef, e_err);
      end
      n_vec++;
      if (mon_q.size() - qb !== nb || mbyte(qb) !== e0) begin
        n_err++; $display("FAIL rnd%0d_addr got %0d/%h exp %0d/%h", it, mon_q.size() - qb, mbyte(qb), nb, e0);
      end
      n_vec++;
      if (aa && mbyte(qb+1) !== e1) begin
        n_err++; $display("FAIL rnd%0d_data got %h exp %h", it, mbyte(qb+1), e1);
      end
      n_vec++;
      if (mack(ab) !== !aa) begin n_err++; $display("FAIL rnd%0d_aack got %b exp %b", it, mack(ab), !aa); end
      n_vec++;
      if (o_rd_data !== exp_rd) begin
        n_err++; $display("FAIL rnd%0d_rd got %h exp %h", it, o_rd_data, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_nack();
    test_data_nack();
    test_read();
    test_hold_valid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
